fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO write port (w_en/w_data into the write-side pointer block and memory) between NUM_REQ requesters in the w_clk domain.
- Grants one requester at a time for a burst of up to MAX_BURST accepted beats.
- Throttles on the write-side full flag, and returns a per-requester accept strobe.
- Sits directly in front of the write pointer block; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 4, maximum accepted beats per grant (1..15).

Ports:
- w_clk  in  1  write-domain clock; all logic is on the rising edge.
- wrst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; level, held while data is valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  FIFO full from the write pointer block (registered there).
- w_en  out  1  FIFO write enable.
- w_data  out  DATA_WIDTH  FIFO write data.
- req_ack  out  NUM_REQ  one-hot; beat from requester i accepted this cycle.
- grant  out  NUM_REQ  one-hot registered grant; 0 when idle.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (wrst=1 at a clock edge), takes effect on the same edge and overrides everything:
  - state=IDLE, grant=0, beat_cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
  - busy=0; w_en=0 and req_ack=0 from the next cycle.
  - Reset during a burst aborts it; the beat in the reset cycle is not acked.
- Two FSM states, IDLE and GRANT.
- IDLE:
  - If |req, select the first set req scanning last_grant+1, +2, … modulo NUM_REQ.
  - Register grant (one-hot) and last_grant; clear beat_cnt; go to GRANT.
  - If no req, stay in IDLE.
  - w_en=0 in IDLE; arbitration costs exactly one cycle.
- GRANT (g = granted index):
  - w_en = req[g] & ~full, combinational.
  - w_data = req_data slice g. It is driven whenever in GRANT and is don't-care when w_en=0; in IDLE it is 0.
  - req_ack[g] = w_en; all other ack bits are 0.
  - Each cycle with w_en=1: beat_cnt+1.
- Release from GRANT to IDLE, grant cleared next cycle, when either:
  - the accepted beat brings beat_cnt to MAX_BURST; or
  - req[g]=0 (requester done; no beat accepted that cycle).
  - There is always at least one idle cycle between bursts.
- full=1 in GRANT:
  - w_en=0 and no ack; beat_cnt holds; grant is retained indefinitely (no timeout).
  - Resumes the same cycle full deasserts.
- full and req[g] dropping in the same cycle: release takes priority; go to IDLE.
- Changes on non-granted req are ignored until the next IDLE arbitration.
- beat_cnt is sized clog2(MAX_BURST+1) and never wraps; it saturates at release.
- Fairness: a requester continuously requesting is granted within NUM_REQ-1 bursts.
- w_en is never asserted while full=1: no FIFO overflow is possible through this block.

Test Plan:
1. Reset, then req=4'b0001 held, full=0: grant=0001 on the 2nd cycle after req; 4 consecutive w_en/req_ack[0] pulses; IDLE for 1 cycle; re-grant 0001.
2. req=4'b1111 held, full=0: grant order 0001→0010→0100→1000→0001, each burst exactly 4 beats, w_data equal to the granted slice (drive slice i = 8'hA0+i).
3. Requester 1 alone drops req after 2 accepted beats: beat 3 is not acked; busy falls on the next edge; the next arbitration, with req=4'b0101, grants requester 2 (rotation starts after 1).
4. Mid-burst full=1 for 3 cycles after beat 2: w_en=0 and ack=0 for those 3 cycles; grant held; beats 3–4 are accepted after full falls; total of 4 beats.
5. full=1 held from the grant edge: w_en stays 0 throughout; grant held; no FIFO write occurs; deasserting full yields 4 beats.
6. wrst=1 asserted for 1 cycle during beat 2 of a requester 2 burst: next cycle grant=0, busy=0, w_en=0; with req=4'b1111 the next grant is 0001.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters and the shared async-FIFO write side.
// The master side is the requester/FIFO environment; the slave side is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (
        output req, req_data, full,
        input  w_en, w_data, req_ack, grant, busy
    );

    modport slave (
        input  req, req_data, full,
        output w_en, w_data, req_ack, grant, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async-FIFO write port between NUM_REQ requesters.
// One requester owns the port for a burst of up to MAX_BURST accepted beats;
// beats are throttled by the write-side full flag and acknowledged per requester.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                 w_clk,
    input  logic                 wrst,
    fifo_write_arbiter_if.slave  wif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // beat_cnt value at which the next accepted beat completes the burst
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_reg,      state_next;
    logic [NUM_REQ-1:0]   grant_reg,      grant_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     beat_cnt_reg,   beat_cnt_next;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  beat;

    // While in GRANT, last_grant_reg is the granted index
    assign beat = (state_reg == GRANT) && wif.req[last_grant_reg] && !wif.full && !wrst;

    // Unpack requester data and decode the per-requester accept strobe
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign slice[gi]       = wif.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign wif.req_ack[gi] = beat && (last_grant_reg == IDX_W'(gi));
    end

    assign wif.w_en   = beat;
    assign wif.w_data = (state_reg == GRANT) ? slice[last_grant_reg] : '0;
    assign wif.grant  = grant_reg;
    assign wif.busy   = (state_reg == GRANT);

    // Rotating-priority pick: first set req after the last granted index
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant_reg) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && wif.req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next      = GRANT;
                    grant_next      = NUM_REQ'(1) << pick_idx;
                    last_grant_next = pick_idx;
                    beat_cnt_next   = '0;
                end
            end
            GRANT: begin
                // Requester withdrawal wins over full; no beat is taken that cycle
                if (!wif.req[last_grant_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (beat) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == BURST_LAST) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State register; reset aborts any burst and gives requester 0 first priority
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a burst-level model.
module tb_fifo_write_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic w_clk = 1'b0;
    logic wrst;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) wif ();

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .w_clk (w_clk),
        .wrst  (wrst),
        .wif   (wif.slave)
    );

    always #5 w_clk = ~w_clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        wrst     = 1'b1;
        wif.req  = '0;
        wif.full = 1'b0;
        step();
        step();
        wrst = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    // m_g is the granted requester (-1 when idle); m_last the most recent winner.
    bit model_on = 1'b0;
    int m_g      = -1;
    int m_last   = NUM_REQ - 1;
    int m_beats  = 0;

    initial begin
        logic [NUM_REQ-1:0] e_grant;
        logic               e_wen;
        int                 gsafe;
        int                 cand;
        bit                 found;
        forever begin
            @(negedge w_clk);
            if (model_on) begin
                gsafe   = (m_g < 0) ? 0 : m_g;
                e_grant = (m_g < 0) ? '0 : NUM_REQ'(1 << m_g);
                e_wen   = (m_g >= 0) && wif.req[gsafe] && !wif.full;
                check("m_grant", wif.grant, e_grant);
                check("m_busy", wif.busy, m_g >= 0);
                if (!wrst) begin
                    check("m_w_en", wif.w_en, e_wen);
                    check("m_req_ack", wif.req_ack, e_wen ? e_grant : '0);
                    if (m_g < 0)
                        check("m_w_data_idle", wif.w_data, 0);
                    else if (e_wen)
                        check("m_w_data", wif.w_data, wif.req_data[gsafe*DW +: DW]);
                end
            end
            @(posedge w_clk);
            if (wrst) begin
                model_on = 1'b1;
                m_g      = -1;
                m_last   = NUM_REQ - 1;
                m_beats  = 0;
            end else if (model_on) begin
                if (m_g < 0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        cand = (m_last + k) % NUM_REQ;
                        if (!found && wif.req[cand]) begin
                            found   = 1'b1;
                            m_g     = cand;
                            m_last  = cand;
                            m_beats = 0;
                        end
                    end
                end else if (!wif.req[m_g]) begin
                    $display("burst req%0d released early beats=%0d", m_g, m_beats);
                    m_g = -1;
                end else if (!wif.full) begin
                    m_beats++;
                    if (m_beats == MAX_BURST) begin
                        $display("burst req%0d complete beats=%0d", m_g, m_beats);
                        m_g = -1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        logic [7:0] pat;
        logic [3:0] exp_g;
        bit         active;
        int         b;

        wrst         = 1'b1;
        wif.req      = '0;
        wif.full     = 1'b0;
        wif.req_data = 32'hA3A2_A1A0;

        // 1: single requester, back-to-back bursts with one idle gap
        do_reset();
        check("t1_reset_grant", wif.grant, 0);
        check("t1_reset_busy", wif.busy, 0);
        check("t1_reset_w_en", wif.w_en, 0);
        wif.req = 4'b0001;
        #1;
        pat = 8'b1101_1110;
        for (int c = 0; c < 8; c++) begin
            check("t1_w_en", wif.w_en, pat[c]);
            check("t1_grant", wif.grant, pat[c] ? 4'b0001 : 4'b0000);
            check("t1_ack", wif.req_ack, pat[c] ? 4'b0001 : 4'b0000);
            step();
        end
        $display("test 1 complete");

        // 2: all requesting, round-robin order with 4-beat bursts
        do_reset();
        wif.req_data = 32'hA3A2_A1A0;
        wif.req      = 4'b1111;
        #1;
        for (int c = 0; c < 25; c++) begin
            b      = c / 5;
            active = (c % 5) != 0;
            exp_g  = active ? 4'(1 << (b % 4)) : 4'd0;
            check("t2_grant", wif.grant, exp_g);
            check("t2_w_en", wif.w_en, active);
            if (active)
                check("t2_w_data", wif.w_data, 8'hA0 + 8'(b % 4));
            step();
        end
        $display("test 2 complete");

        // 3: requester 1 withdraws after 2 beats; rotation continues after 1
        do_reset();
        wif.req = 4'b0010;
        #1;
        check("t3_c0_grant", wif.grant, 0);
        step();
        check("t3_beat1_ack", wif.req_ack, 4'b0010);
        step();
        check("t3_beat2_ack", wif.req_ack, 4'b0010);
        step();
        wif.req = 4'b0000;
        #1;
        check("t3_drop_w_en", wif.w_en, 0);
        check("t3_drop_ack", wif.req_ack, 0);
        check("t3_drop_busy", wif.busy, 1);
        step();
        check("t3_idle_busy", wif.busy, 0);
        check("t3_idle_grant", wif.grant, 0);
        wif.req = 4'b0101;
        #1;
        step();
        check("t3_next_grant", wif.grant, 4'b0100);
        $display("test 3 complete");

        // 4: full for 3 cycles after beat 2
        do_reset();
        wif.req = 4'b0001;
        #1;
        step();
        check("t4_beat1_ack", wif.req_ack, 4'b0001);
        step();
        check("t4_beat2_ack", wif.req_ack, 4'b0001);
        step();
        wif.full = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("t4_full_w_en", wif.w_en, 0);
            check("t4_full_ack", wif.req_ack, 0);
            check("t4_full_grant", wif.grant, 4'b0001);
            step();
        end
        wif.full = 1'b0;
        #1;
        check("t4_beat3_w_en", wif.w_en, 1);
        step();
        check("t4_beat4_ack", wif.req_ack, 4'b0001);
        step();
        check("t4_after_w_en", wif.w_en, 0);
        check("t4_after_busy", wif.busy, 0);
        $display("test 4 complete");

        // 5: full from the grant edge onward, then released
        do_reset();
        wif.req  = 4'b0001;
        wif.full = 1'b1;
        #1;
        check("t5_c0_grant", wif.grant, 0);
        step();
        for (int c = 0; c < 5; c++) begin
            check("t5_full_w_en", wif.w_en, 0);
            check("t5_full_grant", wif.grant, 4'b0001);
            check("t5_full_busy", wif.busy, 1);
            step();
        end
        wif.full = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("t5_beat_w_en", wif.w_en, 1);
            check("t5_beat_ack", wif.req_ack, 4'b0001);
            step();
        end
        check("t5_after_w_en", wif.w_en, 0);
        check("t5_after_grant", wif.grant, 0);
        $display("test 5 complete");

        // 6: reset during beat 2 of a requester-2 burst
        do_reset();
        wif.req = 4'b0100;
        #1;
        step();
        check("t6_grant", wif.grant, 4'b0100);
        check("t6_beat1_ack", wif.req_ack, 4'b0100);
        step();
        wrst = 1'b1;
        step();
        wrst    = 1'b0;
        wif.req = 4'b1111;
        #1;
        check("t6_rst_grant", wif.grant, 0);
        check("t6_rst_busy", wif.busy, 0);
        check("t6_rst_w_en", wif.w_en, 0);
        step();
        check("t6_next_grant", wif.grant, 4'b0001);
        $display("test 6 complete");

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 7) == 0)
                    wif.req[i] = ~wif.req[i];
            wif.full     = ($urandom_range(0, 3) == 0);
            wif.req_data = $urandom;
            wrst         = ($urandom_range(0, 99) == 0);
            step();
        end
        wrst     = 1'b0;
        wif.req  = '0;
        wif.full = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
